// File: rtl/pio_debounce_irq.sv
// Avalon-MM PIO: debounced inputs with edge capture and masked level irq,
// plus an output register with optional per-bit hardware blink.
module pio_debounce_irq #(
   parameter int IN_WIDTH = 2,
   parameter int OUT_WIDTH = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_MODE = 2,
   parameter logic [OUT_WIDTH-1:0] OUT_RESET = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   output logic [31:0]          avs_readdata,
   input  logic [IN_WIDTH-1:0]  pio_in,
   output logic [OUT_WIDTH-1:0] pio_out,
   output logic                 irq
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(1);

   logic [IN_WIDTH-1:0]            sync_1, sync_2, stable, accept, edge_set;
   logic [IN_WIDTH-1:0]            capture, irq_mask, cap_clr;
   logic [IN_WIDTH-1:0][DB_W-1:0]  db_cnt;
   logic [OUT_WIDTH-1:0]           out_reg, blink_en;
   logic [31:0]                    blink_period, blink_cnt, rd_mux;
   logic                           phase;
   logic                           wr_out, wr_mask, wr_cap, wr_ben, wr_period;

   assign wr_out    = avs_write && (avs_address == 3'd1);
   assign wr_mask   = avs_write && (avs_address == 3'd2);
   assign wr_cap    = avs_write && (avs_address == 3'd3);
   assign wr_ben    = avs_write && (avs_address == 3'd4);
   assign wr_period = avs_write && (avs_address == 3'd5);

   assign cap_clr = wr_cap ? avs_writedata[IN_WIDTH-1:0] : '0;

   // A bit is accepted on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
   always_comb begin
      accept = '0;
      for (int i = 0; i < IN_WIDTH; i++)
         accept[i] = (sync_2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
   end

   always_comb begin
      if (EDGE_MODE == 0)
         edge_set = accept & sync_2;
      else if (EDGE_MODE == 1)
         edge_set = accept & ~sync_2;
      else
         edge_set = accept;
   end

   // Down-counter per bit: 0 = idle, loaded on first mismatch, terminal at 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1 <= '0;
         sync_2 <= '0;
         stable <= '0;
         db_cnt <= '0;
      end else begin
         sync_1 <= pio_in;
         sync_2 <= sync_1;
         stable <= (stable & ~accept) | (sync_2 & accept);
         for (int i = 0; i < IN_WIDTH; i++) begin
            if (sync_2[i] == stable[i] || accept[i])
               db_cnt[i] <= '0;
            else if (db_cnt[i] == '0)
               db_cnt[i] <= DB_LOAD;
            else
               db_cnt[i] <= db_cnt[i] - DB_LAST;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         capture  <= '0;
         irq_mask <= '0;
         out_reg  <= OUT_RESET;
         blink_en <= '0;
         irq      <= 1'b0;
         pio_out  <= OUT_RESET;
      end else begin
         capture <= (capture & ~cap_clr) | edge_set;
         if (wr_mask) irq_mask <= avs_writedata[IN_WIDTH-1:0];
         if (wr_out)  out_reg  <= avs_writedata[OUT_WIDTH-1:0];
         if (wr_ben)  blink_en <= avs_writedata[OUT_WIDTH-1:0];
         irq     <= |(capture & irq_mask);
         pio_out <= out_reg ^ (blink_en & {OUT_WIDTH{phase}});
      end
   end

   // Half-period timer counts down from N-1; phase toggles on reaching 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_period <= '0;
         blink_cnt    <= '0;
         phase        <= 1'b0;
      end else if (wr_period) begin
         blink_period <= avs_writedata;
         blink_cnt    <= (avs_writedata == 32'd0) ? 32'd0 : avs_writedata - 32'd1;
         phase        <= 1'b0;
      end else if (blink_period == 32'd0) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == 32'd0) begin
         blink_cnt <= blink_period - 32'd1;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt - 32'd1;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         3'd0: rd_mux[IN_WIDTH-1:0]  = stable;
         3'd1: rd_mux[OUT_WIDTH-1:0] = out_reg;
         3'd2: rd_mux[IN_WIDTH-1:0]  = irq_mask;
         3'd3: rd_mux[IN_WIDTH-1:0]  = capture;
         3'd4: rd_mux[OUT_WIDTH-1:0] = blink_en;
         3'd5: rd_mux                = blink_period;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         avs_readdata <= '0;
      else if (avs_read)
         avs_readdata <= rd_mux;
   end

endmodule

// File: tb/tb_pio_debounce_irq.sv
// Bench for pio_debounce_irq: directed scenarios plus randomized traffic
// against a cycle-level behavioural model (EDGE_MODE=2 instance).
module tb_pio_debounce_irq;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata, rd0;
   logic [1:0]  pio_in, pio_out, pio_out0;
   logic        irq, irq0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   pio_debounce_irq #(.IN_WIDTH(2), .OUT_WIDTH(2), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2), .OUT_RESET(2'b00)) dut (
      .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
      .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
      .pio_in(pio_in), .pio_out(pio_out), .irq(irq));

   pio_debounce_irq #(.IN_WIDTH(2), .OUT_WIDTH(2), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0), .OUT_RESET(2'b00)) dut0 (
      .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
      .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd0),
      .pio_in(pio_in), .pio_out(pio_out0), .irq(irq0));

   // Behavioural model: stable flips once the synchronised input has disagreed
   // for D consecutive clocks; blink phase is (clocks since period write / N) mod 2.
   logic [1:0]  m_s1, m_s2, m_sync, m_stable, m_cap, m_mask, m_out, m_ben, m_set, m_clr, m_pio_out;
   logic [31:0] m_period, m_rdata;
   logic        m_phase, m_irq;
   int          m_run [2];
   int          m_t;

   function automatic logic [31:0] m_reg(input logic [2:0] a);
      case (a)
         3'd0: return 32'(m_stable);
         3'd1: return 32'(m_out);
         3'd2: return 32'(m_mask);
         3'd3: return 32'(m_cap);
         3'd4: return 32'(m_ben);
         3'd5: return m_period;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_stable = 0; m_cap = 0; m_mask = 0; m_out = 0; m_ben = 0;
         m_period = 0; m_rdata = 0; m_phase = 0; m_irq = 0; m_pio_out = 0; m_t = 0;
         m_run[0] = 0; m_run[1] = 0;
      end else begin
         m_sync = m_s2; m_s2 = m_s1; m_s1 = pio_in;
         if (avs_read) m_rdata = m_reg(avs_address);
         m_irq = |(m_cap & m_mask);
         m_pio_out = m_out ^ (m_ben & {2{m_phase}});
         m_set = 0;
         for (int i = 0; i < 2; i++) begin
            if (m_sync[i] != m_stable[i]) begin
               m_run[i]++;
               if (m_run[i] == D) begin
                  m_stable[i] = m_sync[i]; m_run[i] = 0; m_set[i] = 1'b1;
               end
            end else m_run[i] = 0;
         end
         m_clr = (avs_write && avs_address == 3'd3) ? avs_writedata[1:0] : 2'b00;
         m_cap = (m_cap & ~m_clr) | m_set;
         if (avs_write && avs_address == 3'd5) begin
            m_period = avs_writedata; m_t = 0; m_phase = 0;
         end else if (m_period != 0) begin
            m_t++;
            m_phase = ((m_t / int'(m_period)) % 2) == 1;
         end else m_phase = 0;
         if (avs_write && avs_address == 3'd1) m_out  = avs_writedata[1:0];
         if (avs_write && avs_address == 3'd2) m_mask = avs_writedata[1:0];
         if (avs_write && avs_address == 3'd4) m_ben  = avs_writedata[1:0];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      avs_write = 1; avs_address = a; avs_writedata = d;
      step();
      avs_write = 0;
   endtask

   task automatic bus_read(input logic [2:0] a);
      avs_read = 1; avs_address = a;
      step();
      avs_read = 0;
   endtask

   task automatic test_reset();
      reset = 1; avs_read = 0; avs_write = 0; avs_address = 0; avs_writedata = 0; pio_in = 0;
      repeat (3) step();
      n_cmp++; if (pio_out !== 2'b00) begin n_bad++; $display("FAIL reset_pio_out: got %0h expected 0", pio_out); end
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %0b expected 0", irq); end
      n_cmp++; if (avs_readdata !== 32'd0) begin n_bad++; $display("FAIL reset_readdata: got %0h expected 0", avs_readdata); end
      reset = 0;
      step();
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a));
         n_cmp++;
         if (avs_readdata !== 32'd0) begin n_bad++; $display("FAIL reset_reg%0d: got %0h expected 0", a, avs_readdata); end
      end
   endtask

   task automatic test_debounce();
      logic [31:0] exp;
      pio_in = 2'b01; avs_read = 1; avs_address = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         exp = (k >= 7) ? 32'd1 : 32'd0;
         n_cmp++;
         if (avs_readdata !== exp) begin n_bad++; $display("FAIL debounce_data_k%0d: got %0h expected %0h", k, avs_readdata, exp); end
      end
      avs_read = 0;
      repeat (3) step();
      bus_read(3);
      n_cmp++; if (avs_readdata !== 32'd1) begin n_bad++; $display("FAIL debounce_cap: got %0h expected 1", avs_readdata); end
      n_cmp++; if (rd0 !== 32'd1) begin n_bad++; $display("FAIL debounce_cap_mode0: got %0h expected 1", rd0); end
   endtask

   task automatic test_glitch();
      bus_write(3, 3);
      bus_write(2, 2);
      pio_in[1] = 1'b1;
      repeat (3) step();
      pio_in[1] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL glitch_irq_k%0d: got %0b expected 0", k, irq); end
      end
      bus_read(0);
      n_cmp++; if (avs_readdata !== 32'd1) begin n_bad++; $display("FAIL glitch_data: got %0h expected 1", avs_readdata); end
      bus_read(3);
      n_cmp++; if (avs_readdata !== 32'd0) begin n_bad++; $display("FAIL glitch_cap: got %0h expected 0", avs_readdata); end
   endtask

   task automatic test_irq();
      logic exp;
      bus_write(2, 1);
      pio_in[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         exp = (k >= 7);
         n_cmp++; if (irq !== exp) begin n_bad++; $display("FAIL irq_assert_k%0d: got %0b expected %0b", k, irq, exp); end
      end
      bus_write(3, 1);
      n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_clear_edge: got %0b expected 1", irq); end
      step();
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear_after: got %0b expected 0", irq); end
      pio_in[0] = 1'b1;
      repeat (5) step();
      bus_write(3, 1);
      step();
      n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set_wins: got %0b expected 1", irq); end
      bus_read(3);
      n_cmp++; if (avs_readdata !== 32'd1) begin n_bad++; $display("FAIL cap_set_wins: got %0h expected 1", avs_readdata); end
   endtask

   task automatic test_edge_mode0();
      bus_write(3, 3);
      pio_in[0] = 1'b0;
      repeat (10) step();
      bus_read(3);
      n_cmp++; if (rd0 !== 32'd0) begin n_bad++; $display("FAIL mode0_fall: got %0h expected 0", rd0); end
      n_cmp++; if (avs_readdata !== 32'd1) begin n_bad++; $display("FAIL mode2_fall: got %0h expected 1", avs_readdata); end
      bus_write(3, 3);
      pio_in[0] = 1'b1;
      repeat (10) step();
      bus_read(3);
      n_cmp++; if (rd0 !== 32'd1) begin n_bad++; $display("FAIL mode0_rise: got %0h expected 1", rd0); end
   endtask

   task automatic test_blink();
      logic [1:0] exp;
      bus_write(1, 1);
      bus_write(4, 2);
      bus_write(5, 3);
      for (int k = 1; k <= 12; k++) begin
         step();
         exp = (((k - 1) / 3) % 2 == 1) ? 2'b11 : 2'b01;
         n_cmp++; if (pio_out !== exp) begin n_bad++; $display("FAIL blink_k%0d: got %0h expected %0h", k, pio_out, exp); end
      end
      bus_write(5, 0);
      step();
      for (int k = 0; k < 8; k++) begin
         step();
         n_cmp++; if (pio_out !== 2'b01) begin n_bad++; $display("FAIL blink_off_k%0d: got %0h expected 1", k, pio_out); end
      end
   endtask

   task automatic test_random();
      int r;
      logic [2:0] a;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 2; i++)
            if ($urandom_range(0, 7) == 0) pio_in[i] = ~pio_in[i];
         r = $urandom_range(0, 9);
         a = 3'($urandom_range(0, 7));
         avs_address = a;
         avs_writedata = (a == 3'd5) ? $urandom_range(0, 5) : $urandom;
         avs_write = (r <= 2);
         avs_read = (r == 0) || (r >= 3 && r <= 5);
         step();
         n_cmp++; if (pio_out !== m_pio_out) begin n_bad++; $display("FAIL rand_pio_out c%0d: got %0h expected %0h", c, pio_out, m_pio_out); end
         n_cmp++; if (irq !== m_irq) begin n_bad++; $display("FAIL rand_irq c%0d: got %0b expected %0b", c, irq, m_irq); end
         n_cmp++; if (avs_readdata !== m_rdata) begin n_bad++; $display("FAIL rand_rdata c%0d: got %0h expected %0h", c, avs_readdata, m_rdata); end
      end
      avs_write = 0; avs_read = 0;
   endtask

   task automatic test_reset_mid();
      bus_write(1, 1);
      bus_write(4, 3);
      bus_write(5, 2);
      bus_write(2, 3);
      bus_read(5);
      pio_in = ~pio_in;
      repeat (3) step();
      #2 reset = 1;
      #1;
      n_cmp++; if (pio_out !== 2'b00) begin n_bad++; $display("FAIL mid_reset_pio_out: got %0h expected 0", pio_out); end
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_reset_irq: got %0b expected 0", irq); end
      n_cmp++; if (avs_readdata !== 32'd0) begin n_bad++; $display("FAIL mid_reset_rdata: got %0h expected 0", avs_readdata); end
      pio_in = 0;
      @(negedge clk);
      reset = 0;
      step();
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a));
         n_cmp++;
         if (avs_readdata !== 32'd0) begin n_bad++; $display("FAIL mid_reset_reg%0d: got %0h expected 0", a, avs_readdata); end
      end
      n_cmp++; if (pio_out !== 2'b00) begin n_bad++; $display("FAIL mid_reset_out_after: got %0h expected 0", pio_out); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_glitch();
      test_irq();
      test_edge_mode0();
      test_blink();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
